// File: rtl/controle_busca.sv
// controle_busca: instruction fetch controller.
// Walks a word-addressed instruction memory, registering one instruction per
// cycle, and handles branches, datapath stalls, halt and address-range faults.
//
// Output contract: valida=1 means instrucao/pc_atual hold an instruction that
// was loaded and not yet invalidated by a branch, halt, fault or disable. A new
// instruction replaces it on every BUSCA cycle without a higher-priority event.
// There is no backpressure other than parada.
module controle_busca #(
    parameter logic [31:0] END_INICIAL = 32'd0,
    parameter logic [31:0] END_MAX     = 32'd1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        habilita,
    input  logic        parada,
    input  logic        desvio,
    input  logic [31:0] alvo_desvio,
    input  logic        fim,
    input  logic [31:0] instrucao_mem,
    output logic [31:0] endereco,
    output logic [31:0] instrucao,
    output logic        valida,
    output logic [31:0] pc_atual,
    output logic [1:0]  estado,
    output logic        erro,
    output logic [31:0] contador
);

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        BUSCA  = 2'b01,
        ESPERA = 2'b10,
        PARADO = 2'b11
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instrucao_q, instrucao_d;
    logic [31:0] pc_atual_q, pc_atual_d;
    logic [31:0] contador_q, contador_d;
    logic        valida_q, valida_d;
    logic        erro_q, erro_d;

    // One extra bit so pc+1 from 32'hFFFF_FFFF still compares as out of range.
    logic [32:0] pc_inc;
    logic [32:0] alvo_ext;
    logic [32:0] limite;
    logic        falha_desvio;
    logic        falha_busca;

    assign pc_inc   = {1'b0, pc_q} + 33'd1;
    assign alvo_ext = {1'b0, alvo_desvio};
    assign limite   = {1'b0, END_MAX};

    // A branch loads alvo_desvio into pc; otherwise a fetch (no stall) loads pc+1.
    assign falha_desvio = desvio && (alvo_ext > limite);
    assign falha_busca  = !desvio && !parada && (pc_inc > limite);

    assign endereco  = pc_q;
    assign instrucao = instrucao_q;
    assign valida    = valida_q;
    assign pc_atual  = pc_atual_q;
    assign estado    = estado_q;
    assign erro      = erro_q;
    assign contador  = contador_q;

    // Next-state and register-update decisions, highest priority first.
    always_comb begin
        estado_d    = estado_q;
        pc_d        = pc_q;
        instrucao_d = instrucao_q;
        pc_atual_d  = pc_atual_q;
        contador_d  = contador_q;
        valida_d    = valida_q;
        erro_d      = erro_q;

        case (estado_q)
            OCIOSO: begin
                if (habilita) begin
                    estado_d = BUSCA;
                end
            end

            BUSCA, ESPERA: begin
                if (fim && valida_q) begin
                    // Halt decoded from the held instruction.
                    estado_d = PARADO;
                    valida_d = 1'b0;
                end else if (falha_desvio) begin
                    // Out-of-range branch target: pc stays where it was.
                    erro_d   = 1'b1;
                    valida_d = 1'b0;
                    estado_d = PARADO;
                end else if (falha_busca) begin
                    // The last legal word is still loaded before stopping.
                    instrucao_d = instrucao_mem;
                    pc_atual_d  = pc_q;
                    contador_d  = contador_q + 32'd1;
                    erro_d      = 1'b1;
                    valida_d    = 1'b0;
                    estado_d    = PARADO;
                end else if (!habilita) begin
                    valida_d = 1'b0;
                    estado_d = OCIOSO;
                end else if (desvio) begin
                    // Branch wins over a simultaneous stall.
                    pc_d     = alvo_desvio;
                    valida_d = 1'b0;
                    estado_d = BUSCA;
                end else if (parada) begin
                    estado_d = ESPERA;
                end else begin
                    instrucao_d = instrucao_mem;
                    pc_atual_d  = pc_q;
                    valida_d    = 1'b1;
                    pc_d        = pc_inc[31:0];
                    contador_d  = contador_q + 32'd1;
                    estado_d    = BUSCA;
                end
            end

            default: begin
                // PARADO: terminal until reset.
                estado_d = PARADO;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q    <= OCIOSO;
            pc_q        <= END_INICIAL;
            instrucao_q <= 32'd0;
            pc_atual_q  <= 32'd0;
            contador_q  <= 32'd0;
            valida_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            pc_q        <= pc_d;
            instrucao_q <= instrucao_d;
            pc_atual_q  <= pc_atual_d;
            contador_q  <= contador_d;
            valida_q    <= valida_d;
            erro_q      <= erro_d;
        end
    end

endmodule

// File: tb/tb_controle_busca.sv
// tb_controle_busca: directed scenarios plus randomized runs of controle_busca
// against a behavioural model of the fetch controller.
module tb_controle_busca;

    localparam int          MEM_TOP = 1024;
    localparam logic [31:0] END_INI = 32'd0;
    localparam logic [1:0]  ST_OCIOSO = 2'b00;
    localparam logic [1:0]  ST_BUSCA  = 2'b01;
    localparam logic [1:0]  ST_ESPERA = 2'b10;
    localparam logic [1:0]  ST_PARADO = 2'b11;

    logic        clock;
    logic        reset_n;
    logic        habilita;
    logic        parada;
    logic        desvio;
    logic [31:0] alvo_desvio;
    logic        fim;
    logic [31:0] instrucao_mem;
    logic [31:0] endereco;
    logic [31:0] instrucao;
    logic        valida;
    logic [31:0] pc_atual;
    logic [1:0]  estado;
    logic        erro;
    logic [31:0] contador;

    logic [31:0] mem [0:MEM_TOP];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [1:0]  m_st;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_atual;
    logic [31:0] m_cnt;
    logic        m_valida;
    logic        m_erro;
    logic [31:0] exp_q[$];

    controle_busca #(
        .END_INICIAL(END_INI),
        .END_MAX(32'd1024)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .habilita(habilita),
        .parada(parada),
        .desvio(desvio),
        .alvo_desvio(alvo_desvio),
        .fim(fim),
        .instrucao_mem(instrucao_mem),
        .endereco(endereco),
        .instrucao(instrucao),
        .valida(valida),
        .pc_atual(pc_atual),
        .estado(estado),
        .erro(erro),
        .contador(contador)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational instruction memory
    always_comb begin
        if (endereco <= 32'(MEM_TOP)) instrucao_mem = mem[endereco[10:0]];
        else                          instrucao_mem = 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st       = ST_OCIOSO;
        m_pc       = END_INI;
        m_instr    = 32'd0;
        m_pc_atual = 32'd0;
        m_cnt      = 32'd0;
        m_valida   = 1'b0;
        m_erro     = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_load();
        m_instr    = mem[m_pc[10:0]];
        m_pc_atual = m_pc;
        m_cnt      = m_cnt + 32'd1;
        exp_q.push_back(mem[m_pc[10:0]]);
    endtask

    // One clock of the controller, from the rules: fim, fault, disable, branch, stall, fetch.
    task automatic model_step();
        longint unsigned novo_pc;
        bit carrega_pc;
        if (m_st == ST_OCIOSO) begin
            if (habilita) m_st = ST_BUSCA;
        end else if (m_st != ST_PARADO) begin
            novo_pc    = desvio ? {32'd0, alvo_desvio} : {32'd0, m_pc} + 64'd1;
            carrega_pc = desvio || !parada;
            if (fim && m_valida) begin
                m_st = ST_PARADO; m_valida = 1'b0;
            end else if (carrega_pc && novo_pc > 64'(MEM_TOP)) begin
                if (!desvio) model_load();
                m_erro = 1'b1; m_valida = 1'b0; m_st = ST_PARADO;
            end else if (!habilita) begin
                m_valida = 1'b0; m_st = ST_OCIOSO;
            end else if (desvio) begin
                m_pc = alvo_desvio; m_valida = 1'b0; m_st = ST_BUSCA;
            end else if (parada) begin
                m_st = ST_ESPERA;
            end else begin
                model_load();
                m_valida = 1'b1;
                m_pc = m_pc + 32'd1;
                m_st = ST_BUSCA;
            end
        end
    endtask

    task automatic compare_all();
        check("estado", {30'd0, estado}, {30'd0, m_st});
        check("valida", {31'd0, valida}, {31'd0, m_valida});
        check("instrucao", instrucao, m_instr);
        check("pc_atual", pc_atual, m_pc_atual);
        check("endereco", endereco, m_pc);
        check("erro", {31'd0, erro}, {31'd0, m_erro});
        check("contador", contador, m_cnt);
        if (exp_q.size() > 0) check("load", instrucao, exp_q.pop_front());
    endtask

    task automatic drive(input logic h, input logic p, input logic d,
                         input logic [31:0] a, input logic f);
        habilita    = h;
        parada      = p;
        desvio      = d;
        alvo_desvio = a;
        fim         = f;
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic drive_random();
        logic [31:0] a;
        if ($urandom_range(0, 99) < 5) a = 32'($urandom_range(1025, 1100));
        else                           a = 32'($urandom_range(0, MEM_TOP));
        drive($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 10, a, $urandom_range(0, 99) < 3);
    endtask

    initial begin
        for (int i = 0; i <= MEM_TOP; i++) mem[i] = 32'(i + 100);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        apply_reset();
        check("rst_estado", {30'd0, estado}, 32'd0);

        // Sequential run
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step();
        step(); check("seq_i0", instrucao, 32'd100); check("seq_pa0", pc_atual, 32'd0);
        step(); check("seq_i1", instrucao, 32'd101); check("seq_pa1", pc_atual, 32'd1);
        step(); check("seq_i2", instrucao, 32'd102); check("seq_pa2", pc_atual, 32'd2);
        check("seq_cnt", contador, 32'd3); check("seq_val", {31'd0, valida}, 32'd1);
        step(); step();
        check("pre_br_pc", endereco, 32'd5);

        // Branch
        drive(1'b1, 1'b0, 1'b1, 32'd40, 1'b0);
        step(); check("br_val", {31'd0, valida}, 32'd0); check("br_end", endereco, 32'd40);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(); check("br_instr", instrucao, 32'd140); check("br_pa", pc_atual, 32'd40);

        // Stall for three cycles, then resume at the same pc
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_st", {30'd0, estado}, 32'd2);
            check("stall_instr", instrucao, 32'd140);
            check("stall_pc", endereco, 32'd41);
            check("stall_cnt", contador, 32'd6);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(); check("resume_instr", instrucao, 32'd141); check("resume_st", {30'd0, estado}, 32'd1);

        // Stall and branch together: branch wins
        drive(1'b1, 1'b1, 1'b1, 32'd10, 1'b0);
        step(); check("coll_end", endereco, 32'd10); check("coll_st", {30'd0, estado}, 32'd1);
        check("coll_val", {31'd0, valida}, 32'd0);

        // Halt, then inputs are ignored
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(); check("halt_pre", instrucao, 32'd110);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        step(); check("halt_st", {30'd0, estado}, 32'd3); check("halt_val", {31'd0, valida}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            drive(i[0], i[1], ~i[0], 32'd20, 1'b0);
            step(); check("parado_st", {30'd0, estado}, 32'd3);
        end

        // Branch out of range
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(); step();
        drive(1'b1, 1'b0, 1'b1, 32'd1025, 1'b0);
        step(); check("bf_erro", {31'd0, erro}, 32'd1); check("bf_st", {30'd0, estado}, 32'd3);
        check("bf_pc", endereco, 32'd1);

        // Sequential fetch of the last word
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'd1023, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(); check("ff_i1023", instrucao, 32'd1123); check("ff_erro0", {31'd0, erro}, 32'd0);
        step(); check("ff_i1024", instrucao, 32'd1124); check("ff_erro1", {31'd0, erro}, 32'd1);
        check("ff_st", {30'd0, estado}, 32'd3); check("ff_pc", endereco, 32'd1024);

        // Asynchronous reset mid-run
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) step();
        check("ar_pc7", endereco, 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("ar_cnt", contador, 32'd0);
        @(posedge clock); #1;
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;
        step(); step();
        check("ar_first", pc_atual, 32'd0); check("ar_first_i", instrucao, 32'd100);

        // Randomized episodes
        for (int e = 0; e < 20; e++) begin
            for (int i = 0; i <= MEM_TOP; i++) mem[i] = $urandom;
            apply_reset();
            for (int c = 0; c < 200; c++) begin
                drive_random();
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
